// File: rtl/ps2_command_tx.sv
// ps2_command_tx
//   Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
//   over the shared open-drain PS2_CLK / PS2_DAT lines. The sequence is:
//     1. Inhibit the clock.
//     2. Request-to-send (start bit).
//     3. Shift the data bits, the odd parity bit and the stop bit, one per
//        device-generated falling edge.
//     4. Check the device ACK, then wait for both lines to return high.
//
// Ports
//   CLOCK_50   in     system clock, rising edge
//   reset      in     synchronous, active-high
//   cmd_data   in  8  command byte, captured on accept
//   cmd_valid  in     command request (ignored while busy)
//   cmd_ready  out    high only when idle and able to accept
//   cmd_done   out    one-cycle pulse: ACK received and lines back high
//   cmd_error  out    one-cycle pulse: NACK (or watchdog expiry)
//   busy       out    high in every state except IDLE
//   PS2_CLK    inout  open-drain: driven 0 or released
//   PS2_DAT    inout  open-drain: driven 0 or released
//
// Build option
//   PS2_TX_TIMEOUT_EN : when defined, adds two watchdogs that both return the
//     block to IDLE with a cmd_error pulse:
//       - START_TIMEOUT: from clock release to the first device edge.
//       - XFER_TIMEOUT:  from the first device edge to the end of the transfer.
//     When undefined, the block waits indefinitely for the device.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic       busy,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  // One counter serves both the inhibit interval and the watchdogs.
  // These phases never overlap, so it is sized for the largest of the three.
  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > XFER_TIMEOUT) ? MAX_AB : XFER_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT - 1);
`endif

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bit_reg, bit_next;
  logic [7:0]       data_reg, data_next;
  logic             parity_reg, parity_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  // Two-flop synchronizers. Bit 0 is the clock line, bit 1 is the data line.
  // They reset to 1, which is the idle level of the bus.
  logic [1:0] meta_reg, sync_reg;
  logic       clk_prev_reg;
  logic       clk_fall;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      meta_reg     <= 2'b11;
      sync_reg     <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      meta_reg     <= {PS2_DAT, PS2_CLK};
      sync_reg     <= meta_reg;
      clk_prev_reg <= sync_reg[0];
    end
  end

  assign clk_fall = clk_prev_reg & ~sync_reg[0];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= 4'd0;
      data_reg   <= 8'd0;
      parity_reg <= 1'b0;
      done_reg   <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      data_reg   <= data_next;
      parity_reg <= parity_next;
      done_reg   <= done_next;
      error_reg  <= error_next;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  logic xfer_tick;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    data_next   = data_reg;
    parity_next = parity_reg;
    done_next   = 1'b0;
    error_next  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    xfer_tick   = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          data_next   = cmd_data;
          parity_next = ~^cmd_data;
          bit_next    = 4'd0;
          cnt_next    = '0;
          state_next  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_reg == INH_LAST) begin
          cnt_next   = '0;
          state_next = REQ;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      REQ: begin
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (clk_fall) begin
          bit_next = bit_reg + 4'd1;
          // The tenth edge is the stop-bit slot: the data line is released.
          if (bit_reg == 4'd9) state_next = ACK;
        end
`ifdef PS2_TX_TIMEOUT_EN
        if (bit_reg == 4'd0) begin
          if (clk_fall) begin
            cnt_next = '0;  // transfer watchdog starts at the first edge
          end else if (cnt_reg == START_LAST) begin
            state_next = IDLE;
            error_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else begin
          xfer_tick = 1'b1;
        end
`endif
      end
      ACK: begin
        if (clk_fall) begin
          if (sync_reg[1]) begin
            state_next = IDLE;
            error_next = 1'b1;
          end else begin
            state_next = WAIT_IDLE;
          end
        end
`ifdef PS2_TX_TIMEOUT_EN
        xfer_tick = 1'b1;
`endif
      end
      WAIT_IDLE: begin
        if (sync_reg[0] && sync_reg[1]) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
`ifdef PS2_TX_TIMEOUT_EN
        xfer_tick = 1'b1;
`endif
      end
      default: state_next = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // Expiry wins over a coincident done, so done and error stay exclusive.
    if (xfer_tick) begin
      if (cnt_reg == XFER_LAST) begin
        state_next = IDLE;
        error_next = 1'b1;
        done_next  = 1'b0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
`endif
  end

  // Open-drain line drive. The block only ever pulls a line low or releases it.
  // In SHIFT, bit_reg = k selects what goes on the data line:
  //   k = 0     start bit (low)
  //   k = 1..8  data bit k-1
  //   k = 9     parity bit
  //   k = 10    released (stop bit)
  logic clk_low, dat_low;

  always_comb begin
    clk_low = (state_reg == INHIBIT) || (state_reg == REQ);
    dat_low = 1'b0;
    if (state_reg == REQ) begin
      dat_low = 1'b1;
    end else if (state_reg == SHIFT) begin
      if (bit_reg == 4'd0)
        dat_low = 1'b1;
      else if (bit_reg <= 4'd8)
        dat_low = ~data_reg[3'(bit_reg - 4'd1)];
      else if (bit_reg == 4'd9)
        dat_low = ~parity_reg;
    end
  end

  assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

  // A new command is not accepted during the done/error cycle. The earliest
  // re-accept is therefore the cycle after the pulse.
  assign cmd_ready = (state_reg == IDLE) && !done_reg && !error_reg;
  assign busy      = (state_reg != IDLE);
  assign cmd_done  = done_reg;
  assign cmd_error = error_reg;

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb_ps2_command_tx
//   Testbench for ps2_command_tx.
//   - A PS/2 device model clocks the DUT, records the frame it sees and
//     returns ACK or NACK.
//   - A table of fixed commands is applied first, then randomized commands
//     are checked against a parity/frame reference model.
//   - Hand-written sequences cover: reset mid-transfer, back-to-back accept
//     with cmd_valid held high, and a device that never clocks.
//   - Define PS2_TX_TIMEOUT_EN to match a watchdog-enabled DUT build.
module tb_ps2_command_tx;

  localparam int INH      = 40;
  localparam int START_TO = 300;
  localparam int XFER_TO  = 1500;
  localparam int HALF     = 12;   // device clock half period, in system cycles

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  wire        cmd_ready, cmd_done, cmd_error, busy;
  wire        ps2_clk, ps2_dat;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START_TO),
    .XFER_TIMEOUT  (XFER_TO)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .cmd_data (cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_done (cmd_done),
    .cmd_error(cmd_error),
    .busy     (busy),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int ready_pulse_cnt = 0;

  // Pulse monitor: counts done/error pulses and flags any protocol overlap.
  always @(posedge clk) begin
    if (cmd_done === 1'b1) done_cnt <= done_cnt + 1;
    if (cmd_error === 1'b1) err_cnt <= err_cnt + 1;
    if (cmd_done === 1'b1 && cmd_error === 1'b1) both_cnt <= both_cnt + 1;
    if ((cmd_done === 1'b1 || cmd_error === 1'b1) && cmd_ready === 1'b1)
      ready_pulse_cnt <= ready_pulse_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: odd parity makes the total count of ones odd.
  // Frame layout, bit 0 first: start 0, data LSB-first, parity, stop 1.
  function automatic bit model_parity(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] b, input bit par);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Presents a command and waits for the handshake. Returns at the negedge of
  // cycle 1, i.e. the first cycle after the accept edge.
  task automatic send(input logic [7:0] b, output bit ok);
    int n;
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (cmd_ready === 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Device side of one transfer, starting in cycle 1.
  // abort_after > 0 stops after that many clock pulses.
  task automatic run_frame(input bit nack, input int abort_after, output logic [10:0] frame);
    int n;
    bit clk_held;
    frame = '0;
    n = 0;
    clk_held = 1'b1;
    while (ps2_dat === 1'b1 && n < INH + 50) begin
      if (ps2_clk !== 1'b0) clk_held = 1'b0;
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("inhibit_clk_low", clk_held, 1);
    check("req_clk_low", ps2_clk === 1'b0, 1);
    @(negedge clk);
    check("clk_released_after_req", ps2_clk === 1'b1, 1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      frame[i] = ps2_dat;
      if (abort_after != 0 && i == abort_after) return;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    frame[10] = ps2_dat;
    dev_dat_low = !nack;
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic finish_txn(input int exp_done, input int exp_err, input int d0, input int e0);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_drops", busy === 1'b0, 1);
    @(negedge clk);
    check("ready_after_pulse", cmd_ready === 1'b1, 1);
    check("lines_released", (ps2_clk === 1'b1) && (ps2_dat === 1'b1), 1);
    check("done_count", done_cnt - d0, exp_done);
    check("error_count", err_cnt - e0, exp_err);
  endtask

  task automatic do_txn(input int idx, input logic [7:0] b, input bit nack,
                        input bit exp_par, input int exp_done, input int exp_err);
    logic [10:0] frame;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b, ok);
    check("accept", ok, 1);
    check("busy_after_accept", busy === 1'b1, 1);
    run_frame(nack, 0, frame);
    check("frame", frame, model_frame(b, exp_par));
    finish_txn(exp_done, exp_err, d0, e0);
    $display("txn %0d data=%02h nack=%0b frame=%03h done=%0d err=%0d",
             idx, b, nack, frame, done_cnt - d0, err_cnt - e0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         nack;
    bit         exp_par;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [10:0] frame;
    logic [7:0]  rb;
    bit          ok, rn;
    int          d0, e0, n;

    vecs[0] = '{8'hED, 1'b0, 1'b1, 1, 0};
    vecs[1] = '{8'h01, 1'b0, 1'b0, 1, 0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{8'hF4, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    repeat (4) @(negedge clk);
    check("reset_ready", cmd_ready === 1'b1, 1);
    check("reset_busy", busy === 1'b0, 1);
    check("reset_done", cmd_done === 1'b0, 1);
    check("reset_error", cmd_error === 1'b0, 1);
    check("reset_lines", (ps2_clk === 1'b1) && (ps2_dat === 1'b1), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven commands.
    for (int i = 0; i < 5; i++)
      do_txn(i, vecs[i].data, vecs[i].nack, vecs[i].exp_par, vecs[i].exp_done, vecs[i].exp_err);

    // Randomized commands against the reference model.
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      rn = ($urandom_range(0, 3) == 0);
      do_txn(100 + i, rb, rn, model_parity(rb), rn ? 0 : 1, rn ? 1 : 0);
    end

    // Reset after the 4th device falling edge.
    // Data 0x00 keeps the data line pulled low at that point.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00, ok);
    check("abort_accept", ok, 1);
    run_frame(1'b0, 4, frame);
    check("abort_dat_driven", ps2_dat === 1'b0, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_lines_released", (ps2_clk === 1'b1) && (ps2_dat === 1'b1), 1);
    check("abort_ready", cmd_ready === 1'b1, 1);
    check("abort_busy", busy === 1'b0, 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_error", err_cnt - e0, 0);
    $display("txn abort data=00 reset after 4 edges done=%0d err=%0d", done_cnt - d0, err_cnt - e0);
    do_txn(200, 8'hFF, 1'b0, 1'b1, 1, 0);

    // cmd_valid held high with cmd_data changed mid-transfer.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    cmd_data  = 8'h55;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("b2b_first_busy", busy === 1'b1, 1);
    cmd_data = 8'hAA;
    run_frame(1'b0, 0, frame);
    check("b2b_first_frame", frame, model_frame(8'h55, model_parity(8'h55)));
    n = 0;
    while (cmd_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", cmd_done === 1'b1, 1);
    check("b2b_ready_during_done", cmd_ready === 1'b0, 1);
    @(negedge clk);
    check("b2b_ready_next", cmd_ready === 1'b1, 1);
    check("b2b_idle_next", busy === 1'b0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_second_accept", busy === 1'b1, 1);
    run_frame(1'b0, 0, frame);
    check("b2b_second_frame", frame, model_frame(8'hAA, model_parity(8'hAA)));
    finish_txn(2, 0, d0, e0);
    $display("txn b2b data=55,AA done=%0d err=%0d", done_cnt - d0, err_cnt - e0);

    // Device that never clocks.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h3C, ok);
    check("stall_accept", ok, 1);
`ifdef PS2_TX_TIMEOUT_EN
    n = 1;
    while (cmd_error !== 1'b1 && n < INH + START_TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("start_timeout_cycle", n, 1 + INH + 1 + START_TO);
    check("timeout_lines_released", (ps2_clk === 1'b1) && (ps2_dat === 1'b1), 1);
    @(negedge clk);
    check("timeout_ready", cmd_ready === 1'b1, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    $display("txn stall data=3C error at cycle %0d", n);
`else
    repeat (1000) @(negedge clk);
    check("stall_still_busy", busy === 1'b1, 1);
    check("stall_no_error", err_cnt - e0, 0);
    check("stall_clk_released", ps2_clk === 1'b1, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("stall_reset_recovers", cmd_ready === 1'b1, 1);
    check("stall_reset_lines", (ps2_clk === 1'b1) && (ps2_dat === 1'b1), 1);
    $display("txn stall data=3C busy held, recovered by reset");
`endif
    repeat (5) @(negedge clk);

    check("no_done_error_overlap", both_cnt, 0);
    check("ready_low_during_pulse", ready_pulse_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
